// File: rtl/prienc_4to2.sv
// 4-to-2 priority encoder (a3 highest) with combinational outputs and a
// registered copy plus a one-cycle pulse whenever the registered encoding changes.
module prienc_4to2 (
  input  logic                clk,
  input  logic                rst,
  input  logic                a0,
  input  logic                a1,
  input  logic                a2,
  input  logic                a3,
  output logic [1:0]          out,
  output logic                valid,
  output logic [1:0]          out_q,
  output logic                valid_q,
  output logic                chg_q
);

  localparam int unsigned ENC_W = 2;

  logic [ENC_W:0] enc;
  logic [ENC_W:0] enc_q;

  // Priority encode; all-zero and a0-only share out=0 and differ only in valid.
  always_comb begin
    out   = ENC_W'(0);
    valid = a3 | a2 | a1 | a0;
    if (a3) begin
      out = ENC_W'(3);
    end else if (a2) begin
      out = ENC_W'(2);
    end else if (a1) begin
      out = ENC_W'(1);
    end
  end

  assign enc   = {valid, out};
  assign enc_q = {valid_q, out_q};

  // Registered copy; chg_q flags a difference against the value held before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= ENC_W'(0);
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      out_q   <= out;
      valid_q <= valid;
      chg_q   <= (enc != enc_q);
    end
  end

endmodule

// File: tb/tb_prienc_4to2.sv
// Directed self-checking bench for prienc_4to2: combinational sweep, reset,
// latency, priority override, zero-vs-a0 and mid-operation reset.
module tb_prienc_4to2;

  logic       clk;
  logic       rst;
  logic       a0, a1, a2, a3;
  logic [1:0] out;
  logic       valid;
  logic [1:0] out_q;
  logic       valid_q;
  logic       chg_q;

  int checks = 0;
  int errors = 0;

  // Hand-computed encoding for {a3,a2,a1,a0} = 0..15.
  logic [1:0] exp_out_tab [16] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                                   2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};

  prienc_4to2 dut (
    .clk     (clk),
    .rst     (rst),
    .a0      (a0),
    .a1      (a1),
    .a2      (a2),
    .a3      (a3),
    .out     (out),
    .valid   (valid),
    .out_q   (out_q),
    .valid_q (valid_q),
    .chg_q   (chg_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  task automatic set_in(input logic [3:0] v);
    {a3, a2, a1, a0} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string name, input logic [1:0] eo, input logic ev, input logic ec);
    // per-register comparisons kept inline below; this task only groups three of them
    checks++;
    if (out_q !== eo) begin
      $display("FAIL %s out_q: got %0d expected %0d", name, out_q, eo);
      errors++;
    end
    checks++;
    if (valid_q !== ev) begin
      $display("FAIL %s valid_q: got %0b expected %0b", name, valid_q, ev);
      errors++;
    end
    checks++;
    if (chg_q !== ec) begin
      $display("FAIL %s chg_q: got %0b expected %0b", name, chg_q, ec);
      errors++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_in(4'b0000);
    tick();
    chk_reg("initial_reset", 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_comb_sweep();
    logic [3:0] v;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      set_in(v);
      #1;
      checks++;
      if (out !== exp_out_tab[i]) begin
        $display("FAIL sweep_out[%b]: got %0d expected %0d", v, out, exp_out_tab[i]);
        errors++;
      end
      checks++;
      if (valid !== (i != 0)) begin
        $display("FAIL sweep_valid[%b]: got %0b expected %0b", v, valid, (i != 0));
        errors++;
      end
      #4;
    end
  endtask

  task automatic test_comb_under_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(4'b0110);
    #1;
    checks++;
    if (out !== 2'd2) begin
      $display("FAIL rst_comb_out: got %0d expected 2", out);
      errors++;
    end
    checks++;
    if (valid !== 1'b1) begin
      $display("FAIL rst_comb_valid: got %0b expected 1", valid);
      errors++;
    end
    tick();
    chk_reg("rst_comb_regs", 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_latency();
    @(negedge clk);
    rst = 1'b0;
    set_in(4'b1000);
    tick();
    chk_reg("latency_first", 2'd3, 1'b1, 1'b1);
    tick();
    chk_reg("latency_hold", 2'd3, 1'b1, 1'b0);
  endtask

  task automatic test_priority();
    @(negedge clk);
    set_in(4'b0011);
    tick();
    tick();
    chk_reg("prio_base", 2'd1, 1'b1, 1'b0);
    @(negedge clk);
    set_in(4'b1011);
    #1;
    checks++;
    if (out !== 2'd3) begin
      $display("FAIL prio_comb_out: got %0d expected 3", out);
      errors++;
    end
    tick();
    chk_reg("prio_reg", 2'd3, 1'b1, 1'b1);
  endtask

  task automatic test_zero_vs_a0();
    @(negedge clk);
    set_in(4'b0001);
    tick();
    tick();
    chk_reg("a0_only", 2'd0, 1'b1, 1'b0);
    @(negedge clk);
    set_in(4'b0000);
    tick();
    chk_reg("zero_edge", 2'd0, 1'b0, 1'b1);
    tick();
    chk_reg("zero_hold", 2'd0, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    set_in(4'b0100);
    tick();
    tick();
    chk_reg("mid_pre", 2'd2, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_reg("mid_rst", 2'd0, 1'b0, 1'b0);
    checks++;
    if (out !== 2'd2 || valid !== 1'b1) begin
      $display("FAIL mid_rst_comb: got out=%0d valid=%0b expected out=2 valid=1", out, valid);
      errors++;
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_reg("mid_resume", 2'd2, 1'b1, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    set_in(4'b0000);
    test_reset();
    test_comb_sweep();
    test_comb_under_reset();
    test_latency();
    test_priority();
    test_zero_vs_a0();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prienc_4to2.md
PRIENC_4TO2 -- requirements
Module: prienc_4to2

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL have one clock and a reset that is synchronous and active-high.
REQ-003 Port clk, input, 1 bit: rising-edge clock for all registered outputs.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 Port a0, input, 1 bit: request line 0, lowest priority.
REQ-006 Port a1, input, 1 bit: request line 1.
REQ-007 Port a2, input, 1 bit: request line 2.
REQ-008 Port a3, input, 1 bit: request line 3, highest priority.
REQ-009 Port out, output, 2 bits: combinational encoded index of the highest-priority asserted request.
REQ-010 Port valid, output, 1 bit: combinational; 1 when any of a3..a0 is 1.
REQ-011 Port out_q, output, 2 bits: out registered on clk.
REQ-012 Port valid_q, output, 1 bit: valid registered on clk.
REQ-013 Port chg_q, output, 1 bit: registered one-cycle pulse marking a change of the registered encoding.

Function
REQ-014 out SHALL be 2'd3 when a3=1, regardless of a2..a0.
REQ-015 out SHALL be 2'd2 when a3=0 and a2=1, regardless of a1 and a0.
REQ-016 out SHALL be 2'd1 when a3=0, a2=0 and a1=1, regardless of a0.
REQ-017 out SHALL be 2'd0 when a3..a1 are all 0, including the all-zero case.
- The all-zero case is distinguished from a0-only only by valid.
REQ-018 out and valid SHALL be purely combinational, with zero clock latency.
- They SHALL be independent of clk and rst, including while rst=1.
- They SHALL settle within the same time step as an input change.
REQ-019 valid SHALL equal a3|a2|a1|a0.
REQ-020 On each rising clk edge with rst=0:
- out_q SHALL load the current out.
- valid_q SHALL load the current valid.
- Latency from input to these outputs is one cycle.
REQ-021 On each rising clk edge with rst=0, chg_q SHALL load 1 when {valid,out} differs from the {valid_q,out_q} held before the edge, and 0 otherwise.
- A sustained input produces exactly one chg_q pulse.
REQ-022 Inputs with X/Z values are outside the required behaviour. Outputs are undefined only while such values are present.
REQ-023 The block SHALL hold no state other than out_q, valid_q and chg_q.

Reset
REQ-024 On a rising clk edge with rst=1, the block SHALL set out_q=2'd0, valid_q=0 and chg_q=0.
REQ-025 Reset SHALL take priority over every input condition.
REQ-026 Reset asserted mid-operation SHALL clear the registered outputs at the next edge. out and valid SHALL continue to track the inputs.
REQ-027 On the first edge after rst deasserts, the registers SHALL resume normal loading.
- chg_q SHALL pulse on that edge if {valid,out} is non-zero.

Verification
REQ-028 The bench SHALL cover an exhaustive combinational sweep.
- Apply all 16 values of {a3,a2,a1,a0}, 5 time units apart.
- Required out: 0000/0001 -> 0; 001x -> 1; 01xx -> 2; 1xxx -> 3.
- Required valid: 0 only for 0000.
REQ-029 The bench SHALL cover combinational behaviour under reset.
- Hold rst=1 and apply {a3..a0}=0110.
- Required: out=2 and valid=1 immediately; out_q=0, valid_q=0 and chg_q=0 after the edge.
REQ-030 The bench SHALL cover registered latency.
- After reset, apply 1000 and then clock once.
- Required: out_q=3, valid_q=1, chg_q=1.
- On the next edge with 1000 unchanged: chg_q=0.
REQ-031 The bench SHALL cover priority override.
- With 0011 held and registered, set a3=1 (1011).
- Required: out=3 at once; out_q=3 and chg_q=1 after one edge.
REQ-032 The bench SHALL cover the zero versus a0 distinction.
- Step 0001 -> 0000 across edges.
- Required: out_q stays 0, valid_q goes 1 -> 0, and chg_q pulses once.
REQ-033 The bench SHALL cover reset mid-operation.
- With out_q=2, assert rst for one edge.
- Required: out_q=0, valid_q=0, chg_q=0.
- After rst=0 with 0100 still applied: out_q=2 and chg_q=1 at the next edge.
